// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data memory responder.
// Holds the FSM state encoding and the default datapath widths.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefAddrW = 3;

  // Wide enough for the largest supported wait-state count (15).
  localparam int unsigned CntW     = 4;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Register-array data memory: synchronous write, registered read port,
// whole array cleared asynchronously by rst.
module data_mem_responder_mem_array #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      if (re) begin
        rdata_q <= mem_q[raddr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one r/w strobe at a time, inserts WAIT_CYC
// wait states, then completes with a one-cycle rdy pulse.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r,
  input  logic              w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic              busy,
  output logic              err,
  output logic              ovr
);

  localparam logic [CntW-1:0] WaitCnt = CntW'(WAIT_CYC);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_wr_q, op_wr_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                ovr_q, ovr_d;

  logic                mem_we;
  logic                mem_re;
  logic [ADDR_W-1:0]   mem_raddr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    err_d     = 1'b0;
    ovr_d     = ovr_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = addr_q;

    unique case (state_q)
      StIdle: begin
        if (r ^ w) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_wr_d = w;
          cnt_d   = WaitCnt;
          if (WAIT_CYC > 0) begin
            state_d = StWait;
          end else begin
            state_d = StDone;
            // No wait states: read straight from the live address so rdata
            // is valid alongside rdy.
            mem_re    = r;
            mem_raddr = addr;
          end
        end else if (r && w) begin
          err_d = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StDone;
          mem_re  = ~op_wr_q;
        end
      end
      StDone: begin
        mem_we  = op_wr_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if ((state_q != StIdle) && (r || w)) begin
      ovr_d = 1'b1;
    end

    rdy_d  = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  data_mem_responder_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rdata)
  );

  assign rdy  = rdy_q;
  assign busy = busy_q;
  assign err  = err_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with none; read results are checked against a scoreboard queue.
module tb_data_mem_responder;

  typedef struct {
    bit         is_rd;
    logic [3:0] data;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0, w0, r1, w1;
  logic [2:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic [3:0] rdata0, rdata1;
  logic       rdy0, busy0, err0, ovr0;
  logic       rdy1, busy1, err1, ovr1;

  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       sb[$];
  logic [3:0] model [2][8];
  int         wc [2] = '{2, 0};

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(4), .ADDR_W(3), .WAIT_CYC(2)) u_dut0 (
    .clk(clk), .rst(rst), .r(r0), .w(w0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .rdy(rdy0), .busy(busy0), .err(err0), .ovr(ovr0)
  );

  data_mem_responder #(.DATA_W(4), .ADDR_W(3), .WAIT_CYC(0)) u_dut1 (
    .clk(clk), .rst(rst), .r(r1), .w(w1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .rdy(rdy1), .busy(busy1), .err(err1), .ovr(ovr1)
  );

  function automatic logic get_rdy(input int sel);
    return (sel != 0) ? rdy1 : rdy0;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel != 0) ? err1 : err0;
  endfunction
  function automatic logic get_ovr(input int sel);
    return (sel != 0) ? ovr1 : ovr0;
  endfunction
  function automatic logic [3:0] get_rdata(input int sel);
    return (sel != 0) ? rdata1 : rdata0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rv, input logic wv,
                       input logic [2:0] a, input logic [3:0] d);
    if (sel != 0) begin
      r1 = rv; w1 = wv; addr1 = a; wdata1 = d;
    end else begin
      r0 = rv; w0 = wv; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 2; s++) begin
      check({tag, "_rdy"},   get_rdy(s),   1'b0);
      check({tag, "_busy"},  get_busy(s),  1'b0);
      check({tag, "_err"},   get_err(s),   1'b0);
      check({tag, "_ovr"},   get_ovr(s),   1'b0);
      check({tag, "_rdata"}, get_rdata(s), 4'h0);
    end
  endtask

  // One access; 'intrude' fires a second write (addr 1, 4'hF) during the wait.
  task automatic access(input int sel, input bit is_wr, input logic [2:0] a,
                        input logic [3:0] d, input bit intrude);
    exp_t e;
    exp_t got;
    bit   seen;
    e.is_rd = !is_wr;
    e.data  = model[sel][a];
    e.lat   = wc[sel] + 1;
    if (is_wr) model[sel][a] = d;
    sb.push_back(e);
    @(negedge clk);
    drive(sel, !is_wr, is_wr, a, d);
    @(posedge clk);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("busy_first_cycle", get_busy(sel), 1'b1);
        // Scramble addr/data to show the latched copies are used.
        if (intrude) drive(sel, 1'b0, 1'b1, 3'd1, 4'hF);
        else         drive(sel, 1'b0, 1'b0, a ^ 3'd7, ~d);
      end else if (cyc == 2) begin
        drive(sel, 1'b0, 1'b0, a ^ 3'd7, ~d);
      end
      if (get_rdy(sel)) begin
        seen = 1'b1;
        got  = sb.pop_front();
        check("rdy_latency", cyc, got.lat);
        if (got.is_rd) check("rdata", get_rdata(sel), got.data);
      end
    end
    check("rdy_seen", seen, 1'b1);
    if (!seen) void'(sb.pop_front());
    @(negedge clk);
    check("rdy_one_cycle", get_rdy(sel), 1'b0);
    check("busy_after_rdy", get_busy(sel), 1'b0);
  endtask

  initial begin
    int rdy_cnt;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) model[s][i] = 4'h0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 3'd0, 4'h0);
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fresh memory reads back zero.
    access(0, 1'b0, 3'd6, 4'h0, 1'b0);
    access(1, 1'b0, 3'd6, 4'h0, 1'b0);

    // Write/read with two wait states.
    access(0, 1'b1, 3'd5, 4'hA, 1'b0);
    access(0, 1'b0, 3'd5, 4'h0, 1'b0);

    // Write/read with no wait states.
    access(1, 1'b1, 3'd7, 4'h3, 1'b0);
    access(1, 1'b0, 3'd7, 4'h0, 1'b0);
    access(1, 1'b1, 3'd0, 4'hC, 1'b0);
    access(1, 1'b0, 3'd0, 4'h0, 1'b0);

    // Collision: r and w together.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'd5, 4'h2);
    @(posedge clk);
    @(negedge clk);
    check("collision_err", err0, 1'b1);
    check("collision_rdy", rdy0, 1'b0);
    check("collision_busy", busy0, 1'b0);
    drive(0, 1'b0, 1'b0, 3'd0, 4'h0);
    @(negedge clk);
    check("collision_err_pulse", err0, 1'b0);
    check("collision_no_rdy", rdy0, 1'b0);
    check("collision_ovr", ovr0, 1'b0);
    access(0, 1'b0, 3'd5, 4'h0, 1'b0);

    // Overrun: second write arrives during the wait states.
    access(0, 1'b1, 3'd4, 4'h6, 1'b1);
    check("ovr_set", ovr0, 1'b1);
    access(0, 1'b0, 3'd1, 4'h0, 1'b0);
    access(0, 1'b0, 3'd4, 4'h0, 1'b0);
    check("ovr_sticky", ovr0, 1'b1);
    check("ovr_other_dut", ovr1, 1'b0);

    // Abort: reset during the wait of a write to addr 2.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 3'd2, 4'h9);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'd0, 4'h0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) model[s][i] = 4'h0;
    rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdy0) rdy_cnt++;
    end
    check("abort_no_rdy", rdy_cnt, 0);
    check("abort_idle", busy0, 1'b0);
    access(0, 1'b0, 3'd2, 4'h0, 1'b0);
    access(0, 1'b0, 3'd5, 4'h0, 1'b0);
    access(1, 1'b0, 3'd7, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
